wb_arbiter: RTL and testbench

Write-back arbiter that shares one register-file write port between N execution units (alu, fpu, imm, jump, mov).
- Each unit presents a write request (5-bit reg address, 32-bit data, 3-bit conveyor stamp).
- Round-robin grant, one write per cycle, registered onto the reg_file write port.
- In the same cycle as the write, emits the stamp of the retired instruction so pool/conveyor can release the slot.

---
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter that shares a single register-file write
// port between N execution units (alu, fpu, imm, jump, mov).
//
// A round-robin search picks at most one valid requester per cycle. The
// winner's address, data and stamp are registered and presented on the
// register-file port one cycle later. In that same cycle, the stamp is
// reported so the conveyor can release the slot.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   stop            - pipeline stop; blocks new grants, freezes the pointer
//   req_valid       - per-unit write request
//   req_addr_flat   - per-unit register address, unit i at [i*AW +: AW]
//   req_data_flat   - per-unit write data,       unit i at [i*DW +: DW]
//   req_stamp_flat  - per-unit conveyor stamp,   unit i at [i*SW +: SW]
//   req_ready       - one-hot combinational grant
//   reg_search_in   - register-file write address
//   reg_in          - register-file write data
//   reg_in_start    - register-file write enable (one pulse per write)
//   done_stamp      - stamp of the instruction being written
//   done_in         - stamp valid, identical to reg_in_start
//   grant_idx       - unit written this cycle, 0 when idle
//   conflict_cnt    - saturating count of cycles with two or more requests
module wb_arbiter #(
   parameter int N  = 5,
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int SW = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stop,
   input  logic [N-1:0]    req_valid,
   input  logic [N*AW-1:0] req_addr_flat,
   input  logic [N*DW-1:0] req_data_flat,
   input  logic [N*SW-1:0] req_stamp_flat,
   output logic [N-1:0]    req_ready,
   output logic [AW-1:0]   reg_search_in,
   output logic [DW-1:0]   reg_in,
   output logic            reg_in_start,
   output logic [SW-1:0]   done_stamp,
   output logic            done_in,
   output logic [2:0]      grant_idx,
   output logic [15:0]     conflict_cnt
);

   logic [2:0]    ptr_q, ptr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic [SW-1:0] stamp_q, stamp_d;
   logic          start_q, start_d;
   logic [2:0]    idx_q, idx_d;
   logic [15:0]   cnt_q, cnt_d;

   logic          grant_hit;
   logic [2:0]    grant_sel;

   // Round-robin search: first look at indices at or above the pointer,
   // then wrap around to the low indices if nothing was found there.
   always_comb begin
      grant_hit = 1'b0;
      grant_sel = '0;
      if (!reset && !stop) begin
         for (int i = 0; i < N; i++) begin
            if (!grant_hit && req_valid[i] && (i >= int'(ptr_q))) begin
               grant_hit = 1'b1;
               grant_sel = 3'(i);
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!grant_hit && req_valid[i]) begin
               grant_hit = 1'b1;
               grant_sel = 3'(i);
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_ready[i] = grant_hit && (grant_sel == 3'(i));
      end
   end

   // Capture the winner for the output stage. The pointer moves past the
   // winner only on a transfer, so stop or an idle cycle leaves it in place.
   // Address, data and stamp keep their last values when nothing is written.
   always_comb begin
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      stamp_d = stamp_q;
      start_d = 1'b0;
      idx_d   = '0;
      if (grant_hit) begin
         start_d = 1'b1;
         idx_d   = grant_sel;
         ptr_d   = (grant_sel == 3'(N - 1)) ? 3'd0 : grant_sel + 3'd1;
         for (int i = 0; i < N; i++) begin
            if (grant_sel == 3'(i)) begin
               addr_d  = req_addr_flat[i*AW +: AW];
               data_d  = req_data_flat[i*DW +: DW];
               stamp_d = req_stamp_flat[i*SW +: SW];
            end
         end
      end
   end

   // Contention counter, independent of stop, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (($countones(req_valid) >= 2) && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         stamp_q <= '0;
         start_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         stamp_q <= stamp_d;
         start_q <= start_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign reg_search_in = addr_q;
   assign reg_in        = data_q;
   assign reg_in_start  = start_q;
   assign done_stamp    = stamp_q;
   assign done_in       = start_q;
   assign grant_idx     = idx_q;
   assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter (N=5). A reference model
// keeps the round-robin pointer as a plain integer, and it keeps the
// expected output stage and counter as ordinary variables.
module tb_wb_arbiter;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         reset;
   logic         stop;
   logic [4:0]   req_valid;
   logic [24:0]  req_addr_flat;
   logic [159:0] req_data_flat;
   logic [14:0]  req_stamp_flat;
   logic [4:0]   req_ready;
   logic [4:0]   reg_search_in;
   logic [31:0]  reg_in;
   logic         reg_in_start;
   logic [2:0]   done_stamp;
   logic         done_in;
   logic [2:0]   grant_idx;
   logic [15:0]  conflict_cnt;

   logic [4:0]   u_addr  [N];
   logic [31:0]  u_data  [N];
   logic [2:0]   u_stamp [N];

   int checks = 0;
   int errors = 0;

   // Reference model state
   int           m_ptr;
   int           m_cnt;
   bit           m_start;
   int           m_idx;
   logic [4:0]   m_addr;
   logic [31:0]  m_data;
   logic [2:0]   m_stamp;
   int           last_grant;

   wb_arbiter #(.N(5), .AW(5), .DW(32), .SW(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .stop           (stop),
      .req_valid      (req_valid),
      .req_addr_flat  (req_addr_flat),
      .req_data_flat  (req_data_flat),
      .req_stamp_flat (req_stamp_flat),
      .req_ready      (req_ready),
      .reg_search_in  (reg_search_in),
      .reg_in         (reg_in),
      .reg_in_start   (reg_in_start),
      .done_stamp     (done_stamp),
      .done_in        (done_in),
      .grant_idx      (grant_idx),
      .conflict_cnt   (conflict_cnt)
   );

   always #5 clk = ~clk;

   // Pack the per-unit request fields into the flat buses.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_addr_flat[i*5 +: 5]   = u_addr[i];
         req_data_flat[i*32 +: 32] = u_data[i];
         req_stamp_flat[i*3 +: 3]  = u_stamp[i];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scan the units in rotating order from the pointer and return the first
   // valid one, or -1 if nothing may be granted.
   function automatic int modelGrant();
      if (reset || stop) return -1;
      for (int k = 0; k < N; k++) begin
         if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic int countValid();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(req_valid[i]);
      return c;
   endfunction

   // One clock cycle: inputs are already driven (we are just past a falling
   // edge). Check the grant, step the model at the rising edge, then check
   // the registered outputs.
   task automatic applyStimulus();
      int g;
      logic [4:0] exp_ready;
      #1;
      g = modelGrant();
      exp_ready = (g >= 0) ? (5'b00001 << g) : 5'b00000;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      @(posedge clk);
      if (reset) begin
         m_ptr = 0; m_cnt = 0; m_start = 0; m_idx = 0;
         m_addr = '0; m_data = '0; m_stamp = '0;
      end else begin
         if (g >= 0) begin
            m_start = 1; m_idx = g;
            m_addr = u_addr[g]; m_data = u_data[g]; m_stamp = u_stamp[g];
            m_ptr = (g + 1) % N;
         end else begin
            m_start = 0; m_idx = 0;
         end
         if (countValid() >= 2 && m_cnt < 65535) m_cnt++;
      end
      last_grant = g;
      #1;
      checkOutput("reg_in_start",  32'(reg_in_start),  32'(m_start));
      checkOutput("done_in",       32'(done_in),       32'(m_start));
      checkOutput("grant_idx",     32'(grant_idx),     32'(m_idx));
      checkOutput("reg_search_in", 32'(reg_search_in), 32'(m_addr));
      checkOutput("reg_in",        reg_in,             m_data);
      checkOutput("done_stamp",    32'(done_stamp),    32'(m_stamp));
      checkOutput("conflict_cnt",  32'(conflict_cnt),  32'(m_cnt));
      @(negedge clk);
   endtask

   task automatic setUnit(input int u, input logic [4:0] a, input logic [31:0] d, input logic [2:0] s);
      u_addr[u] = a; u_data[u] = d; u_stamp[u] = s;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stop = 1'b0; req_valid = '0;
      for (int i = 0; i < N; i++) setUnit(i, 5'(i + 1), 32'h1000 + 32'(i), 3'(i));
      m_ptr = 0; m_cnt = 0; m_start = 0; m_idx = 0;
      m_addr = '0; m_data = '0; m_stamp = '0; last_grant = -1;
      @(negedge clk);
      doReset();
      doReset();

      // Single request from unit 2
      setUnit(2, 5'd7, 32'hDEADBEEF, 3'd4);
      req_valid = 5'b00100;
      #1 checkOutput("single_ready", 32'(req_ready), 32'h4);
      applyStimulus();
      checkOutput("single_addr",  32'(reg_search_in), 32'd7);
      checkOutput("single_data",  reg_in, 32'hDEADBEEF);
      checkOutput("single_stamp", 32'(done_stamp), 32'd4);
      checkOutput("single_idx",   32'(grant_idx), 32'd2);
      req_valid = 5'b00000;
      applyStimulus();

      // Round-robin with all units valid for 10 cycles
      doReset();
      req_valid = 5'b11111;
      for (int k = 0; k < 10; k++) begin
         applyStimulus();
         checkOutput("rr_order", 32'(grant_idx), 32'(k % N));
      end
      checkOutput("rr_conflicts", 32'(conflict_cnt), 32'd10);

      // Wrap-around: grant 3 so the pointer sits at 4, then units 0 and 4
      req_valid = 5'b01000;
      applyStimulus();
      req_valid = 5'b10001;
      applyStimulus();
      checkOutput("wrap_first", 32'(grant_idx), 32'd4);
      req_valid = 5'b00001;
      applyStimulus();
      checkOutput("wrap_second", 32'(grant_idx), 32'd0);

      // stop with units 1 and 3 pending; pointer is 1
      req_valid = 5'b01010;
      stop = 1'b1;
      for (int k = 0; k < 3; k++) applyStimulus();
      stop = 1'b0;
      applyStimulus();
      checkOutput("stop_resume", 32'(grant_idx), 32'd1);
      req_valid = 5'b01000;
      applyStimulus();
      req_valid = 5'b00000;
      applyStimulus();

      // Reset right after a transfer from unit 0
      req_valid = 5'b00001;
      applyStimulus();
      req_valid = 5'b00000;
      doReset();
      checkOutput("rst_start", 32'(reg_in_start), 32'd0);
      checkOutput("rst_cnt",   32'(conflict_cnt), 32'd0);

      // Randomized traffic obeying the hold-until-ready rule
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < N; u++) begin
            if (!req_valid[u] || last_grant == u) begin
               req_valid[u] = 1'($urandom_range(0, 1));
               setUnit(u, 5'($urandom), $urandom, 3'($urandom));
            end
         end
         stop  = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 49) == 0);
         applyStimulus();
      end
      reset = 1'b0; stop = 1'b0;

      // Counter saturation: two requests held under stop for >65535 cycles
      doReset();
      stop = 1'b1;
      req_valid = 5'b00011;
      applyStimulus();
      for (int c = 0; c < 65600; c++) begin
         @(posedge clk);
         if (m_cnt < 65535) m_cnt++;
      end
      @(negedge clk);
      checkOutput("sat_cnt", 32'(conflict_cnt), 32'hFFFF);
      applyStimulus();
      checkOutput("sat_hold", 32'(conflict_cnt), 32'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
